multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max wait cycles for mem_ready before fault (range 1..255).
REQ-002 SHALL have port clk, input, 1: single clock, all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port Opc, input, 6: opcode of the instruction latched in IR.
REQ-005 SHALL have port mem_ready, input, 1: memory completed the current access this cycle.
REQ-006 SHALL have port zero, input, 1: ALU zero flag.
REQ-007 SHALL have outputs PCWrite, IRWrite, RegWrite, MemToWrite, MemRead, Memtoreg, RegDst, ALUSrcA, IorD, 1 bit each: datapath strobes and mux selects.
REQ-008 SHALL have outputs ALUSrcB, 2, and PCSrc, 2: ALU B and PC source selects.
REQ-009 SHALL have output ALUOp, 3: 000 add, 010 sub, 001 R-type via funct.
REQ-010 SHALL have outputs fault, 1: sticky illegal-opcode/timeout flag; and state_o, 4: current state for debug.

Function
REQ-011 SHALL implement states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH, JUMP, HALT.
REQ-012 FETCH SHALL assert MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000; on mem_ready it SHALL pulse IRWrite and PCWrite (PCSrc=00) and go to DECODE, else stay.
REQ-013 DECODE SHALL compute branch target (ALUSrcA=0, ALUSrcB=11, ALUOp=000) and branch on Opc: 000000->EXEC_R, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, other->HALT.
REQ-014 EXEC_R SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=001, then go to R_WB; R_WB SHALL assert RegWrite, RegDst=1, Memtoreg=0, then FETCH.
REQ-015 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=000; next MEM_RD for 100011, MEM_WR for 101011.
REQ-016 MEM_RD SHALL assert MemRead, IorD=1 until mem_ready, then MEM_WB; MEM_WB SHALL assert RegWrite, RegDst=0, Memtoreg=1, then FETCH.
REQ-017 MEM_WR SHALL assert MemToWrite, IorD=1 until mem_ready, then FETCH; MemToWrite SHALL drop the cycle after mem_ready.
REQ-018 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=010, PCSrc=01 and assert PCWrite only if zero=1; then FETCH (3-cycle beq).
REQ-019 All outputs not listed for a state SHALL be 0 (never X); outputs SHALL be decoded from the registered state only (Moore), except IRWrite/PCWrite in FETCH and PCWrite in BRANCH.
REQ-020 A wait counter SHALL count cycles spent in FETCH/MEM_RD/MEM_WR without mem_ready; reaching MEM_TIMEOUT SHALL set fault and enter HALT; counter clears on every state change.
REQ-021 mem_ready in the first cycle of a memory state SHALL complete that access (zero-wait memory supported).
REQ-022 HALT SHALL drive all strobes 0, hold fault=1, and be left only by reset.
REQ-023 Latency without waits: R-type 4, lw 5, sw 4, beq 3, j 3 cycles.

Reset
REQ-024 rst_n low SHALL asynchronously force state FETCH, wait counter 0, fault 0, all strobes 0, even mid-access; first fetch begins on the first clk edge after release.

Configuration
REQ-025 With MULTICYCLE_CTRL_JUMP_EN defined, Opc 000010 SHALL go to JUMP (PCSrc=10, PCWrite=1, then FETCH); without it, 000010 SHALL be illegal -> HALT, fault=1, and JUMP SHALL not exist.

Structure
REQ-026 Opcode constants, ALUOp encodings, and state encoding SHALL live in a shared package mips_pkg reused by the decoder and the ALU control.
REQ-027 The timeout counter SHALL be sub-module mc_wait_timer (inputs clr, en; output expired).

Verification
REQ-028 Reset: rst_n=0 mid-MEM_WR -> MemToWrite=0 and state_o=FETCH immediately, fault=0.
REQ-029 lw with mem_ready high always -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; RegWrite=1, Memtoreg=1 only in the 5th cycle.
REQ-030 beq with zero=1 then zero=0 -> PCWrite pulse with PCSrc=01 in BRANCH only for zero=1; 3 cycles each.
REQ-031 MEM_TIMEOUT=4, mem_ready held 0 in MEM_RD -> fault=1 and HALT after 4 cycles; stays until reset.
REQ-032 Opc=111111 -> HALT after DECODE, fault=1; Opc=000010 -> JUMP with macro, HALT without.
REQ-033 sw with mem_ready asserted on 3rd wait cycle -> MemToWrite high exactly 3 cycles, then FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode, ALUOp, mux-select and state encodings for the multicycle controller.
// Optional macro MULTICYCLE_CTRL_JUMP_EN adds the JUMP state and the j opcode dispatch.
package mips_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_J     = 6'b000010;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_FUNCT = 3'b001;
   localparam logic [2:0] ALUOP_SUB   = 3'b010;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEM_ADDR = 4'd2;
   localparam logic [3:0] S_MEM_RD   = 4'd3;
   localparam logic [3:0] S_MEM_WB   = 4'd4;
   localparam logic [3:0] S_MEM_WR   = 4'd5;
   localparam logic [3:0] S_EXEC_R   = 4'd6;
   localparam logic [3:0] S_R_WB     = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
`ifdef MULTICYCLE_CTRL_JUMP_EN
   localparam logic [3:0] S_JUMP     = 4'd9;
`endif
   localparam logic [3:0] S_HALT     = 4'd10;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       alu_src_a;
      logic       i_or_d;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_op;
   } ctrl_t;

   // Opcode dispatch out of DECODE; anything unrecognised is treated as illegal.
   function automatic logic [3:0] decode_next(input logic [5:0] opc);
      case (opc)
         OPC_RTYPE:      return S_EXEC_R;
         OPC_LW, OPC_SW: return S_MEM_ADDR;
         OPC_BEQ:        return S_BRANCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
         OPC_J:          return S_JUMP;
`endif
         default:        return S_HALT;
      endcase
   endfunction

   function automatic logic [2:0] alu_ctl(input logic [3:0] st);
      case (st)
         S_EXEC_R: return ALUOP_FUNCT;
         S_BRANCH: return ALUOP_SUB;
         default:  return ALUOP_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state watchdog: down-counter reloaded on clr, decremented on en;
// expired flags the en cycle that exhausts the LIMIT budget.
module mc_wait_timer #(
   parameter int unsigned LIMIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LOAD = 8'(LIMIT - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= LOAD;
      end else if (clr) begin
         cnt <= LOAD;
      end else if (en && (cnt != 8'd0)) begin
         cnt <= cnt - 8'd1;
      end
   end

   assign expired = en && (cnt == 8'd0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with memory wait-state watchdog and sticky fault.
// Optional macro MULTICYCLE_CTRL_JUMP_EN enables the j instruction (JUMP state).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4; IR/PC written on mem_ready
// DECODE   | compute branch target, dispatch on Opc
// MEM_ADDR | effective address = base + imm
// MEM_RD   | load access, wait for mem_ready
// MEM_WB   | write load data to rt
// MEM_WR   | store access, wait for mem_ready
// EXEC_R   | R-type ALU operation via funct
// R_WB     | write ALU result to rd
// BRANCH   | beq compare, PC <= target when zero
// JUMP     | PC <= jump target (only with MULTICYCLE_CTRL_JUMP_EN)
// HALT     | illegal opcode or timeout, left only by reset
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Opc,
   input  logic       mem_ready,
   input  logic       zero,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemToWrite,
   output logic       MemRead,
   output logic       Memtoreg,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic       IorD,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUOp,
   output logic       fault,
   output logic [3:0] state_o
);

   import mips_pkg::*;

   logic [3:0] state, state_nxt;
   logic       fault_q, fault_nxt;
   logic       active;
   logic       wait_st;
   logic       tmr_en, tmr_clr, expired;
   ctrl_t      ctrl;

   // Keeps the controller idle until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
      end else begin
         active <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         fault_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         fault_q <= fault_nxt;
      end
   end

   assign wait_st = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign tmr_en  = active && wait_st && !mem_ready;
   assign tmr_clr = !active || (state_nxt != state);

   mc_wait_timer #(
      .LIMIT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (expired)
   );

   always_comb begin
      state_nxt = state;
      fault_nxt = fault_q;
      if (active) begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  state_nxt = S_DECODE;
               end else if (expired) begin
                  state_nxt = S_HALT;
                  fault_nxt = 1'b1;
               end
            end
            S_DECODE: begin
               state_nxt = decode_next(Opc);
               if (decode_next(Opc) == S_HALT) begin
                  fault_nxt = 1'b1;
               end
            end
            S_MEM_ADDR: begin
               if (Opc == OPC_LW) begin
                  state_nxt = S_MEM_RD;
               end else if (Opc == OPC_SW) begin
                  state_nxt = S_MEM_WR;
               end else begin
                  state_nxt = S_HALT;
                  fault_nxt = 1'b1;
               end
            end
            S_MEM_RD: begin
               if (mem_ready) begin
                  state_nxt = S_MEM_WB;
               end else if (expired) begin
                  state_nxt = S_HALT;
                  fault_nxt = 1'b1;
               end
            end
            S_MEM_WR: begin
               if (mem_ready) begin
                  state_nxt = S_FETCH;
               end else if (expired) begin
                  state_nxt = S_HALT;
                  fault_nxt = 1'b1;
               end
            end
            S_MEM_WB: state_nxt = S_FETCH;
            S_EXEC_R: state_nxt = S_R_WB;
            S_R_WB:   state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            S_JUMP:   state_nxt = S_FETCH;
`endif
            S_HALT: begin
               state_nxt = S_HALT;
               fault_nxt = 1'b1;
            end
            default: begin
               state_nxt = S_HALT;
               fault_nxt = 1'b1;
            end
         endcase
      end
   end

   // Moore decode from state; only the FETCH IR/PC strobes and the beq PC strobe look at inputs.
   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = alu_ctl(state);
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.pc_src    = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SHL;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
         end
         S_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.pc_src    = PCSRC_BRANCH;
            ctrl.pc_write  = zero;
         end
`ifdef MULTICYCLE_CTRL_JUMP_EN
         S_JUMP: begin
            ctrl.pc_src   = PCSRC_JUMP;
            ctrl.pc_write = 1'b1;
         end
`endif
         default: ;
      endcase
      if (!active) begin
         ctrl = '0;
      end
   end

   assign PCWrite    = ctrl.pc_write;
   assign IRWrite    = ctrl.ir_write;
   assign RegWrite   = ctrl.reg_write;
   assign MemToWrite = ctrl.mem_write;
   assign MemRead    = ctrl.mem_read;
   assign Memtoreg   = ctrl.mem_to_reg;
   assign RegDst     = ctrl.reg_dst;
   assign ALUSrcA    = ctrl.alu_src_a;
   assign IorD       = ctrl.i_or_d;
   assign ALUSrcB    = ctrl.alu_src_b;
   assign PCSrc      = ctrl.pc_src;
   assign ALUOp      = ctrl.alu_op;
   assign fault      = fault_q;
   assign state_o    = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle stimulus and expected outputs are
// queued per instruction, then replayed and compared cycle by cycle.
module tb_multicycle_ctrl;

   import mips_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [5:0] Opc;
   logic       mem_ready;
   logic       zero;
   logic       PCWrite, IRWrite, RegWrite, MemToWrite, MemRead, Memtoreg;
   logic       RegDst, ALUSrcA, IorD, fault;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUOp;
   logic [3:0] state_o;
   logic [16:0] obs;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [5:0]  opc;
      logic        rdy;
      logic        z;
      logic [3:0]  st;
      logic [16:0] vec;
   } ent_t;

   ent_t sb_q[$];

   multicycle_ctrl #(
      .MEM_TIMEOUT (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Opc        (Opc),
      .mem_ready  (mem_ready),
      .zero       (zero),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .MemToWrite (MemToWrite),
      .MemRead    (MemRead),
      .Memtoreg   (Memtoreg),
      .RegDst     (RegDst),
      .ALUSrcA    (ALUSrcA),
      .IorD       (IorD),
      .ALUSrcB    (ALUSrcB),
      .PCSrc      (PCSrc),
      .ALUOp      (ALUOp),
      .fault      (fault),
      .state_o    (state_o)
   );

   assign obs = {PCWrite, IRWrite, RegWrite, MemToWrite, MemRead, Memtoreg, RegDst,
                 ALUSrcA, IorD, ALUSrcB, PCSrc, ALUOp, fault};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {pcw, irw, rw, mw, mr, m2r, rd, srca, iord, srcb, pcsrc, aluop, fault}
   function automatic logic [16:0] v(input logic pcw, irw, rw, mw, mr, m2r, rd, sa, iod,
                                     input logic [1:0] sb, ps, input logic [2:0] op,
                                     input logic f);
      return {pcw, irw, rw, mw, mr, m2r, rd, sa, iod, sb, ps, op, f};
   endfunction

   task automatic push(input logic [5:0] o, input logic r, input logic z,
                       input logic [3:0] st, input logic [16:0] vec);
      ent_t e;
      e.opc = o; e.rdy = r; e.z = z; e.st = st; e.vec = vec;
      sb_q.push_back(e);
   endtask

   task automatic e_fetch(input logic [5:0] o, input logic r);
      push(o, r, 1'b0, S_FETCH, v(r, r, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0));
   endtask
   task automatic e_dec(input logic [5:0] o, input logic r);
      push(o, r, 1'b0, S_DECODE, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 0));
   endtask
   task automatic e_maddr(input logic [5:0] o, input logic r);
      push(o, r, 1'b0, S_MEM_ADDR, v(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b000, 0));
   endtask
   task automatic e_mrd(input logic [5:0] o, input logic r);
      push(o, r, 1'b0, S_MEM_RD, v(0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 0));
   endtask
   task automatic e_mwb(input logic [5:0] o, input logic r);
      push(o, r, 1'b0, S_MEM_WB, v(0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0));
   endtask
   task automatic e_mwr(input logic [5:0] o, input logic r);
      push(o, r, 1'b0, S_MEM_WR, v(0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 0));
   endtask
   task automatic e_exec(input logic [5:0] o, input logic r);
      push(o, r, 1'b0, S_EXEC_R, v(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b001, 0));
   endtask
   task automatic e_rwb(input logic [5:0] o, input logic r);
      push(o, r, 1'b0, S_R_WB, v(0, 0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 0));
   endtask
   task automatic e_br(input logic [5:0] o, input logic z);
      push(o, 1'b0, z, S_BRANCH, v(z, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 3'b010, 0));
   endtask
   task automatic e_halt(input logic [5:0] o, input logic r);
      push(o, r, 1'b0, S_HALT, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1));
   endtask
`ifdef MULTICYCLE_CTRL_JUMP_EN
   task automatic e_jmp(input logic [5:0] o);
      push(o, 1'b0, 1'b0, S_JUMP, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0));
   endtask
`endif

   // Replays queued cycles: drive inputs, compare mid-cycle, advance one clock.
   task automatic run_queue(input string name);
      ent_t e;
      int   idx;
      idx = 0;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         Opc       = e.opc;
         mem_ready = e.rdy;
         zero      = e.z;
         #2;
         chk($sformatf("%s_c%0d_state", name, idx), 32'(state_o), 32'(e.st));
         chk($sformatf("%s_c%0d_outs", name, idx), 32'(obs), 32'(e.vec));
         @(posedge clk);
         #1;
         idx++;
      end
   endtask

   task automatic do_reset(input string name);
      rst_n = 1'b0;
      #1;
      chk({name, "_state"}, 32'(state_o), 32'(S_FETCH));
      chk({name, "_mw"}, 32'(MemToWrite), 32'd0);
      chk({name, "_fault"}, 32'(fault), 32'd0);
      chk({name, "_outs"}, 32'(obs), 32'd0);
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      #1;
      chk({name, "_hold_outs"}, 32'(obs), 32'd0);
      rst_n = 1'b1;
      #1;
      chk({name, "_rel_outs"}, 32'(obs), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      Opc       = 6'd0;
      mem_ready = 1'b0;
      zero      = 1'b0;
      #12;
      do_reset("rst0");

      // R-type, lw zero-wait, sw with one fetch wait and two write waits, beq taken/not taken
      e_fetch(OPC_RTYPE, 1); e_dec(OPC_RTYPE, 0); e_exec(OPC_RTYPE, 0); e_rwb(OPC_RTYPE, 0);
      e_fetch(OPC_LW, 1); e_dec(OPC_LW, 1); e_maddr(OPC_LW, 1); e_mrd(OPC_LW, 1); e_mwb(OPC_LW, 1);
      e_fetch(OPC_SW, 0); e_fetch(OPC_SW, 1); e_dec(OPC_SW, 0); e_maddr(OPC_SW, 0);
      e_mwr(OPC_SW, 0); e_mwr(OPC_SW, 0); e_mwr(OPC_SW, 1);
      e_fetch(OPC_BEQ, 1); e_dec(OPC_BEQ, 0); e_br(OPC_BEQ, 1);
      e_fetch(OPC_BEQ, 1); e_dec(OPC_BEQ, 0); e_br(OPC_BEQ, 0);
      e_fetch(OPC_RTYPE, 1); e_dec(OPC_RTYPE, 0);
      run_queue("seq");

      // previous R-type is mid-flight; finish it then hit an illegal opcode
      e_exec(OPC_RTYPE, 0); e_rwb(OPC_RTYPE, 0);
      e_fetch(6'b111111, 1); e_dec(6'b111111, 0);
      e_halt(6'b111111, 1); e_halt(6'b111111, 0); e_halt(OPC_RTYPE, 1);
      run_queue("illegal");
      do_reset("rst1");

      // reset asserted in the middle of a store access
      e_fetch(OPC_SW, 1); e_dec(OPC_SW, 0); e_maddr(OPC_SW, 0); e_mwr(OPC_SW, 0);
      run_queue("sw_mid");
      mem_ready = 1'b0;
      #2;
      chk("sw_mid_pre_mw", 32'(MemToWrite), 32'd1);
      do_reset("rst_mid");

      // load timeout after four wait cycles
      e_fetch(OPC_LW, 1); e_dec(OPC_LW, 0); e_maddr(OPC_LW, 0);
      e_mrd(OPC_LW, 0); e_mrd(OPC_LW, 0); e_mrd(OPC_LW, 0); e_mrd(OPC_LW, 0);
      e_halt(OPC_LW, 1); e_halt(OPC_LW, 0);
      run_queue("tmo");
      do_reset("rst2");

`ifdef MULTICYCLE_CTRL_JUMP_EN
      e_fetch(OPC_J, 1); e_dec(OPC_J, 0); e_jmp(OPC_J);
      e_fetch(OPC_RTYPE, 1);
`else
      e_fetch(OPC_J, 1); e_dec(OPC_J, 0); e_halt(OPC_J, 1); e_halt(OPC_J, 0);
`endif
      run_queue("jump");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
